// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default baud divisor and the
// receive state encoding. The transmit side imports the same package.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int IDX_W                = $clog2(DATA_BITS);
  // 100 MHz system clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side signal bundle: serial line in, parallel byte and strobes out.
// slave  = the receive engine, master = the line driver / byte consumer.
interface uart_rx_if;

  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport master (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is
// a parameter so an idle-high line does not look like an edge after reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is safe to use downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receive engine. Detects the start edge on the synchronized line,
// re-checks it at mid-bit, samples each data bit at its centre and checks
// the stop bit before publishing the byte with a one-cycle strobe.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | line idle, waiting for a high-to-low edge on rx_s
//   START | counting to mid start bit; low -> DATA, high -> glitch, IDLE
//   DATA  | sampling 8 data bits LSB first, one per bit period
//   STOP  | sampling the stop bit; high -> rx_valid, low -> frame_err
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic rx_s;
  logic rx_d;

  uart_state_e          state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 valid_q, valid_nxt;
  logic                 ferr_q, ferr_nxt;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  // One extra stage of the synchronized line for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_d <= 1'b1;
    else       rx_d <= rx_s;
  end

  // State register plus all datapath registers driven by the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shreg   <= shreg_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      ferr_q  <= ferr_nxt;
    end
  end

  // Next-state, baud counting, bit capture and strobe generation.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;

    case (state)
      IDLE: begin
        // A line still low after a framing error has rx_d low too, so only
        // a fresh high-to-low transition starts a frame.
        if (rx_d && !rx_s) begin
          cnt_nxt   = '0;
          state_nxt = START;
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            idx_nxt   = '0;
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt        = '0;
          shreg_nxt[idx] = rx_s;
          if (idx == IDX_LAST) state_nxt = STOP;
          else                 idx_nxt   = idx + IDX_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
          end else begin
            ferr_nxt  = 1'b1;
          end
          // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);

  // Strobes are mutually exclusive and never last more than one cycle.
  a_strobe_excl : assert property (@(posedge clk) disable iff (reset)
    !(valid_q && ferr_q));
  a_strobe_single : assert property (@(posedge clk) disable iff (reset)
    (valid_q || ferr_q) |=> !(valid_q || ferr_q));

endmodule

// File: tb/tb_uart_rx.sv
// Randomized, self-checking bench for uart_rx at 16 clocks per bit. The
// reference model is the frame itself: a good stop bit delivers the sent
// byte, a low stop bit yields one frame_err and keeps the last good byte.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int HALF  = 50;
  localparam int CLK_T = 2 * HALF;
  localparam int BIT   = CPB * CLK_T;

  logic clk;
  logic reset;

  uart_rx_if u_if ();

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #HALF clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed activity, sampled on the falling edge.
  int         n_valid   = 0;
  int         n_ferr    = 0;
  int         n_overlap = 0;
  logic [7:0] got_q[$];
  time        t_valid   = 0;
  bit         busy_seen = 0;
  bit         prev_pulse = 0;

  // Reference state: last byte the receiver should be holding.
  logic [7:0] exp_data = 8'h00;

  always @(negedge clk) begin
    if (u_if.rx_valid) begin
      n_valid++;
      got_q.push_back(u_if.rx_data);
      t_valid = $time;
    end
    if (u_if.frame_err) n_ferr++;
    if ((u_if.rx_valid && u_if.frame_err) ||
        ((u_if.rx_valid || u_if.frame_err) && prev_pulse))
      n_overlap++;
    prev_pulse = u_if.rx_valid || u_if.frame_err;
    if (u_if.busy) busy_seen = 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=5000000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic align();
    @(posedge clk);
    #10;
  endtask

  // Drives one 8N1 frame with the given bit time; the line is left at 'tail'.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int bit_t, input logic tail);
    u_if.rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      #(bit_t);
    end
    u_if.rx = stop_bit;
    #(bit_t);
    u_if.rx = tail;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    u_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (u_if.rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", u_if.rx_data);
    else n_pass++;
    n_checks++;
    if (u_if.rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", u_if.rx_valid);
    else n_pass++;
    n_checks++;
    if (u_if.frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", u_if.frame_err);
    else n_pass++;
    align();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (u_if.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", u_if.busy);
    else n_pass++;
    exp_data = 8'h00;
  endtask

  task automatic test_single();
    int  v0, f0, lat;
    time t0;
    v0 = n_valid; f0 = n_ferr;
    align();
    t0 = $time;
    send_frame(8'hA5, 1'b1, BIT, 1'b1);
    repeat (4) @(negedge clk);
    exp_data = 8'hA5;
    n_checks++;
    if (n_valid - v0 !== 1) $display("FAIL single_valid_count: got %0d want 1", n_valid - v0);
    else n_pass++;
    n_checks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] !== 8'hA5)
      $display("FAIL single_data: got %h want a5", (got_q.size() == 0) ? 8'hxx : got_q[got_q.size()-1]);
    else n_pass++;
    // pin edge -> 2 synchronizer clocks -> 9.5 bits -> 1 register clock
    lat = int'((t_valid - t0) / CLK_T);
    n_checks++;
    if (lat < 153 || lat > 157) $display("FAIL single_latency: got %0d cycles want 153..157", lat);
    else n_pass++;
    n_checks++;
    if (n_ferr - f0 !== 0) $display("FAIL single_no_ferr: got %0d want 0", n_ferr - f0);
    else n_pass++;
    n_checks++;
    if (u_if.rx_data !== exp_data) $display("FAIL single_hold: got %h want %h", u_if.rx_data, exp_data);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    got_q.delete();
    align();
    send_frame(8'h3C, 1'b1, BIT, 1'b1);
    send_frame(8'hC3, 1'b1, BIT, 1'b1);
    repeat (4) @(negedge clk);
    exp_data = 8'hC3;
    n_checks++;
    if (n_valid - v0 !== 2) $display("FAIL b2b_valid_count: got %0d want 2", n_valid - v0);
    else n_pass++;
    n_checks++;
    if (got_q.size() < 1 || got_q[0] !== 8'h3C)
      $display("FAIL b2b_first: got %h want 3c", (got_q.size() < 1) ? 8'hxx : got_q[0]);
    else n_pass++;
    n_checks++;
    if (got_q.size() < 2 || got_q[1] !== 8'hC3)
      $display("FAIL b2b_second: got %h want c3", (got_q.size() < 2) ? 8'hxx : got_q[1]);
    else n_pass++;
    n_checks++;
    if (n_ferr - f0 !== 0) $display("FAIL b2b_no_ferr: got %0d want 0", n_ferr - f0);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int v0, f0;
    repeat (4) @(negedge clk);
    v0 = n_valid; f0 = n_ferr;
    busy_seen = 0;
    align();
    u_if.rx = 1'b0;
    #(4 * CLK_T);
    u_if.rx = 1'b1;
    // line driven at P+10: rx_s low in cycle T = P+200; start check at T+8
    repeat (7) @(negedge clk);
    n_checks++;
    if (u_if.busy !== 1'b1) $display("FAIL glitch_busy_at_T8: got %b want 1", u_if.busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (u_if.busy !== 1'b0) $display("FAIL glitch_busy_at_T9: got %b want 0", u_if.busy);
    else n_pass++;
    repeat (3 * CPB) @(negedge clk);
    n_checks++;
    if ((n_valid - v0) + (n_ferr - f0) !== 0)
      $display("FAIL glitch_no_pulse: got %0d pulses want 0", (n_valid - v0) + (n_ferr - f0));
    else n_pass++;
    n_checks++;
    if (u_if.rx_data !== exp_data) $display("FAIL glitch_hold: got %h want %h", u_if.rx_data, exp_data);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    int v0, f0;
    logic [7:0] b;
    v0 = n_valid; f0 = n_ferr;
    align();
    send_frame(8'h55, 1'b0, BIT, 1'b0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (n_ferr - f0 !== 1) $display("FAIL ferr_count: got %0d want 1", n_ferr - f0);
    else n_pass++;
    n_checks++;
    if (u_if.rx_data !== exp_data) $display("FAIL ferr_data_kept: got %h want %h", u_if.rx_data, exp_data);
    else n_pass++;
    busy_seen = 0;
    #(40 * BIT);
    n_checks++;
    if (busy_seen !== 1'b0) $display("FAIL ferr_low_hold_busy: got %b want 0", busy_seen);
    else n_pass++;
    n_checks++;
    if ((n_valid - v0) !== 0 || (n_ferr - f0) !== 1)
      $display("FAIL ferr_low_hold_pulses: got valid %0d ferr %0d want 0 1", n_valid - v0, n_ferr - f0);
    else n_pass++;
    u_if.rx = 1'b1;
    #(2 * BIT);
    b = 8'($urandom_range(0, 255));
    v0 = n_valid;
    send_frame(b, 1'b1, BIT, 1'b1);
    repeat (4) @(negedge clk);
    exp_data = b;
    n_checks++;
    if (n_valid - v0 !== 1 || u_if.rx_data !== exp_data)
      $display("FAIL ferr_recovery: got %0d pulses data %h want 1 pulse data %h", n_valid - v0, u_if.rx_data, exp_data);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int v0, f0;
    align();
    v0 = n_valid; f0 = n_ferr;
    u_if.rx = 1'b0;
    #(BIT);
    u_if.rx = 1'b1;                      // 0xFF: every data bit high
    #(4 * BIT + BIT / 2);                // middle of data bit 4
    reset = 1'b1;
    #(3 * CLK_T);
    n_checks++;
    if (u_if.rx_data !== 8'h00 || u_if.busy !== 1'b0)
      $display("FAIL abort_in_reset: got data %h busy %b want 00 0", u_if.rx_data, u_if.busy);
    else n_pass++;
    reset = 1'b0;
    exp_data = 8'h00;
    #(BIT / 2 - 3 * CLK_T + 4 * BIT);    // rest of bits 4..7 and the stop bit
    repeat (CPB) @(negedge clk);
    n_checks++;
    if ((n_valid - v0) !== 0 || (n_ferr - f0) !== 0)
      $display("FAIL abort_no_pulse: got valid %0d ferr %0d want 0 0", n_valid - v0, n_ferr - f0);
    else n_pass++;
    n_checks++;
    if (u_if.rx_data !== exp_data) $display("FAIL abort_data_cleared: got %h want %h", u_if.rx_data, exp_data);
    else n_pass++;
    align();
    send_frame(8'h81, 1'b1, BIT, 1'b1);
    repeat (4) @(negedge clk);
    exp_data = 8'h81;
    n_checks++;
    if (n_valid - v0 !== 1 || u_if.rx_data !== exp_data)
      $display("FAIL abort_next_frame: got %0d pulses data %h want 1 pulse data %h", n_valid - v0, u_if.rx_data, exp_data);
    else n_pass++;
  endtask

  task automatic test_baud_error(input int bit_t);
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    align();
    send_frame(8'h96, 1'b1, bit_t, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    exp_data = 8'h96;
    n_checks++;
    if (n_valid - v0 !== 1) $display("FAIL baud_%0d_valid: got %0d want 1", bit_t, n_valid - v0);
    else n_pass++;
    n_checks++;
    if (u_if.rx_data !== exp_data) $display("FAIL baud_%0d_data: got %h want %h", bit_t, u_if.rx_data, exp_data);
    else n_pass++;
    n_checks++;
    if (n_ferr - f0 !== 0) $display("FAIL baud_%0d_ferr: got %0d want 0", bit_t, n_ferr - f0);
    else n_pass++;
  endtask

  task automatic test_random();
    int v0, f0, gap;
    logic [7:0] b;
    logic good;
    for (int k = 0; k < 8; k++) begin
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(0, 20);
      v0 = n_valid; f0 = n_ferr;
      got_q.delete();
      repeat (gap) @(posedge clk);
      #($urandom_range(1, CLK_T - 1));
      send_frame(b, good, BIT, 1'b1);
      repeat (4) @(negedge clk);
      if (good) exp_data = b;
      n_checks++;
      if ((n_valid - v0) !== (good ? 1 : 0) || (n_ferr - f0) !== (good ? 0 : 1))
        $display("FAIL rand_%0d_pulses: got valid %0d ferr %0d want %0d %0d",
                 k, n_valid - v0, n_ferr - f0, good ? 1 : 0, good ? 0 : 1);
      else n_pass++;
      n_checks++;
      if (u_if.rx_data !== exp_data)
        $display("FAIL rand_%0d_data: got %h want %h", k, u_if.rx_data, exp_data);
      else n_pass++;
    end
  endtask

  task automatic test_strobe_shape();
    n_checks++;
    if (n_overlap !== 0) $display("FAIL strobe_shape: got %0d overlapping/long strobes want 0", n_overlap);
    else n_pass++;
  endtask

  initial begin
    reset   = 1'b1;
    u_if.rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_abort();
    test_baud_error(BIT + BIT / 50);
    test_baud_error(BIT - BIT / 50);
    test_random();
    test_strobe_shape();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
